truth_table_sweeper: RTL and testbench
======================================

# truth_table_sweeper

Self-checking stimulus sequencer for the combinational logic blocks in this design. It walks all 2^N_IN input combinations onto the shared input bus of two implementations of the same function and compares their outputs after a programmable settle time. It accumulates a mismatch count and the first failing vector, then reports pass/fail. Its role is to replace the free-running `for` loop in the benches with a synthesizable, cycle-exact sweep that can also run on hardware.

## Interface
Parameters:
- N_IN, default 5: number of function inputs. The sweep length is 2^N_IN vectors.
- SETTLE, default 1: number of cycles between driving a vector and sampling the outputs. Legal range is 1..15.

Ports:
- clk, in, 1: single clock, rising edge.
- reset, in, 1: asynchronous, active-high. Forces all state and outputs to their reset values immediately.
- start, in, 1: begins a sweep when sampled high in IDLE.
- abort, in, 1: synchronous cancel of a running sweep.
- vec, out, N_IN: vector driven to both implementations. The MSB maps to X and the LSB maps to M (order X,Y,Z,K,M).
- f_a, in, 1: output of implementation A.
- f_b, in, 1: output of implementation B.
- busy, out, 1: high while a sweep is in progress.
- done, out, 1: one-cycle pulse when a sweep completes normally.
- pass, out, 1: high when the last completed sweep had zero mismatches.
- err_count, out, N_IN+1: number of mismatching vectors. The width holds the full 2^N_IN.
- err_seen, out, 1: at least one mismatch recorded in the current or last sweep.
- first_err, out, N_IN: the first vector that mismatched. Valid only when err_seen=1.

## Operation
- The FSM has four states: IDLE, WAIT, SAMPLE, FINISH.
- IDLE:
  - vec=0, busy=0.
  - When start=1 and abort=0: clear err_count, err_seen, first_err and pass, set vec=0, load the settle counter with SETTLE, and go to WAIT.
- WAIT:
  - Stays for exactly SETTLE cycles with vec held stable, then goes to SAMPLE.
- SAMPLE, one cycle, compares f_a against f_b:
  - If f_a≠f_b: increment err_count. If err_seen=0, also set err_seen=1 and first_err=vec.
  - If vec=2^N_IN-1, go to FINISH. Otherwise increment vec, reload the settle counter, and go to WAIT.
- FINISH, one cycle:
  - done=1 and pass=(err_count==0), using the count that includes the final SAMPLE.
  - Then go to IDLE.
- busy=1 in WAIT, SAMPLE and FINISH.
- start is ignored while busy.
- abort=1 in WAIT or SAMPLE:
  - Go to IDLE on the next edge without asserting done.
  - pass=0. err_count, err_seen and first_err keep their partial values.
  - The SAMPLE comparison in that same cycle is still counted.
- abort and start high together in IDLE: abort wins and the FSM stays in IDLE.
- Results (pass, err_count, err_seen, first_err) hold until the next accepted start or reset.
- vec never wraps. The terminal vector is detected explicitly and the counter does not roll over past 2^N_IN-1.

## Timing
- Reset values: every output is 0 (vec, busy, done, pass, err_count, err_seen, first_err), and the state is IDLE. Asserting reset mid-sweep clears everything asynchronously with no done pulse.
- Let E0 be the edge that samples start. busy rises after E0, and vec=0 is valid from E0.
- Vector k (0-based) is driven from edge E0+k·(SETTLE+1). It is sampled in the cycle ending at edge E0+(k+1)·(SETTLE+1).
- done is high in the cycle that follows edge E0+2^N_IN·(SETTLE+1). With the defaults this is E0+64.
- busy falls one edge after done rises. A new start is accepted on the first IDLE cycle after that.
- f_a and f_b are sampled only in SAMPLE. They may glitch at any other time.

## Test plan
- **Equal functions:** f_a and f_b driven by identical logic of vec, one start pulse → done exactly 64 cycles after the start edge, err_count=0, err_seen=0, pass=1.
- **Single fault:** f_b = f_a XOR (vec==5'b10110) → err_count=1, err_seen=1, first_err=22, pass=0.
- **Full inversion:** f_b = ~f_a → err_count=32, first_err=0, pass=0. Check that vec stops at 31 and never wraps.
- **Abort:** raise abort 20 cycles after start → busy=0 on the next edge, done never pulses, pass=0. A following start completes a clean sweep with pass=1.
- **Reset mid-sweep:** assert reset between edges at cycle 30 → all outputs read 0 before the next edge, and state is IDLE after release.
- **Settle and start filtering:** SETTLE=3, and start is pulsed again at cycle 10 → the second pulse is ignored, each vec value lasts 4 cycles, and done appears 128 cycles after the first start.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: drives every input vector to two implementations,
// compares their outputs after a settle delay and records mismatch statistics.
module truth_table_sweeper #(
  parameter int N_IN   = 5,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            abort,
  output logic [N_IN-1:0] vec,
  input  logic            f_a,
  input  logic            f_b,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            err_seen,
  output logic [N_IN-1:0] first_err
);

  localparam logic [N_IN-1:0] LAST      = '1;
  localparam logic [3:0]      SETTLE_LD = 4'(SETTLE);

  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE, FINISH} state_t;

  state_t        state, state_nxt;
  logic [3:0]    settle_cnt;
  logic          mismatch;
  logic [N_IN:0] count_nxt;

  assign mismatch  = f_a ^ f_b;
  assign count_nxt = err_count + {{N_IN{1'b0}}, mismatch};
  assign busy      = (state != IDLE);
  assign done      = (state == FINISH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !abort) state_nxt = WAIT;
      WAIT: begin
        if (abort)                 state_nxt = IDLE;
        else if (settle_cnt == 4'd1) state_nxt = SAMPLE;
      end
      SAMPLE: begin
        if (abort)             state_nxt = IDLE;
        else if (vec == LAST)  state_nxt = FINISH;
        else                   state_nxt = WAIT;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vec        <= '0;
      settle_cnt <= '0;
      pass       <= 1'b0;
      err_count  <= '0;
      err_seen   <= 1'b0;
      first_err  <= '0;
    end else begin
      case (state)
        IDLE: begin
          vec <= '0;
          if (start && !abort) begin
            err_count  <= '0;
            err_seen   <= 1'b0;
            first_err  <= '0;
            pass       <= 1'b0;
            settle_cnt <= SETTLE_LD;
          end
        end
        WAIT: begin
          if (abort) begin
            vec  <= '0;
            pass <= 1'b0;
          end else begin
            settle_cnt <= settle_cnt - 4'd1;
          end
        end
        SAMPLE: begin
          // the comparison is counted even when this cycle also aborts
          err_count <= count_nxt;
          if (mismatch && !err_seen) begin
            err_seen  <= 1'b1;
            first_err <= vec;
          end
          if (abort) begin
            vec  <= '0;
            pass <= 1'b0;
          end else if (vec == LAST) begin
            pass <= (count_nxt == '0);
          end else begin
            vec        <= vec + 1'b1;
            settle_cnt <= SETTLE_LD;
          end
        end
        FINISH:  vec <= '0;
        default: vec <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: two instances (SETTLE=1 and SETTLE=3) exercised with
// truth-table functions; expectations come from popcount / lowest-bit of the difference table.
module tb_truth_table_sweeper;

  logic clk = 0, reset = 1, start = 0, abort = 0, sel = 0;
  logic [31:0] ta = 0, tb = 0;
  int n_chk = 0, n_pass = 0;

  logic [4:0] vec1, vec3, first1, first3, vec_o, first_o;
  logic [5:0] cnt1, cnt3, cnt_o;
  logic busy1, busy3, done1, done3, pass1, pass3, seen1, seen3;
  logic busy_o, done_o, pass_o, seen_o;

  always #5 clk = ~clk;

  truth_table_sweeper #(.N_IN(5), .SETTLE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start & !sel), .abort(abort & !sel),
    .vec(vec1), .f_a(ta[vec1]), .f_b(tb[vec1]), .busy(busy1), .done(done1),
    .pass(pass1), .err_count(cnt1), .err_seen(seen1), .first_err(first1));

  truth_table_sweeper #(.N_IN(5), .SETTLE(3)) dut3 (
    .clk(clk), .reset(reset), .start(start & sel), .abort(abort & sel),
    .vec(vec3), .f_a(ta[vec3]), .f_b(tb[vec3]), .busy(busy3), .done(done3),
    .pass(pass3), .err_count(cnt3), .err_seen(seen3), .first_err(first3));

  assign vec_o   = sel ? vec3   : vec1;
  assign first_o = sel ? first3 : first1;
  assign cnt_o   = sel ? cnt3   : cnt1;
  assign busy_o  = sel ? busy3  : busy1;
  assign done_o  = sel ? done3  : done1;
  assign pass_o  = sel ? pass3  : pass1;
  assign seen_o  = sel ? seen3  : seen1;

  typedef struct {
    logic [31:0] a, b;
    bit          s3;
    int          restart_at;
    int          exp_cnt, exp_first;
    bit          exp_pass;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // number of differing table entries among the first n vectors
  function automatic int diff_count(input logic [31:0] d, input int n);
    int c = 0;
    for (int i = 0; i < n && i < 32; i++) if (d[i]) c++;
    return c;
  endfunction

  function automatic int lowest(input logic [31:0] d);
    for (int i = 0; i < 32; i++) if (d[i]) return i;
    return 0;
  endfunction

  task automatic check_results(input string tag, input int ec, input int ef, input bit ep);
    chk({tag, ".err_count"}, cnt_o, ec);
    chk({tag, ".err_seen"}, seen_o, ec != 0);
    if (ec != 0) chk({tag, ".first_err"}, first_o, ef);
    chk({tag, ".pass"}, pass_o, ep);
  endtask

  task automatic sweep(input string tag, input bit s3, input logic [31:0] a, input logic [31:0] b,
                       input int restart_at, input int ec, input int ef, input bit ep);
    int settle, total, done_at, done_n;
    bit vec_ok;
    sel = s3; ta = a; tb = b;
    settle = s3 ? 3 : 1;
    total = 32 * (settle + 1);
    done_at = -1; done_n = 0; vec_ok = 1;
    @(negedge clk); start = 1;
    @(posedge clk); #1; start = 0;
    for (int c = 0; c <= total + 1; c++) begin
      if (c > 0) begin @(posedge clk); #1; start = 0; end
      if (done_o) begin done_n++; if (done_at < 0) done_at = c; end
      if (c < total && (vec_o !== 5'(c / (settle + 1)) || busy_o !== 1'b1)) vec_ok = 0;
      if (c == total && vec_o !== 5'd31) vec_ok = 0;
      if (c == restart_at) start = 1;
      if (c == total) check_results(tag, ec, ef, ep);
    end
    chk({tag, ".done_time"}, done_at, total);
    chk({tag, ".done_pulses"}, done_n, 1);
    chk({tag, ".vec_seq"}, vec_ok, 1);
    chk({tag, ".busy_fall"}, {busy_o, done_o, vec_o}, 0);
  endtask

  task automatic abort_test(input string tag, input logic [31:0] a, input logic [31:0] b, input int at);
    int done_n = 0, n;
    logic [31:0] d;
    sel = 0; ta = a; tb = b; d = a ^ b;
    n = at / 2;
    @(negedge clk); start = 1;
    @(posedge clk); #1; start = 0;
    repeat (at - 1) @(posedge clk);
    #1; abort = 1;
    @(posedge clk); #1; abort = 0;
    chk({tag, ".busy_after_abort"}, busy_o, 0);
    chk({tag, ".vec_after_abort"}, vec_o, 0);
    for (int c = 0; c < 80; c++) begin
      if (done_o) done_n++;
      @(posedge clk); #1;
    end
    chk({tag, ".no_done"}, done_n, 0);
    check_results(tag, diff_count(d, n), lowest(d), 0);
  endtask

  vec_t tbl[6];
  logic [31:0] ra, rm;
  logic [5:0]  held;

  initial begin
    tbl[0] = '{32'hA5A5_1234, 32'hA5A5_1234, 0, -1, 0, 0, 1};
    tbl[1] = '{32'h0F0F_3C3C, 32'h0F0F_3C3C ^ 32'h0040_0000, 0, -1, 1, 22, 0};
    tbl[2] = '{32'h1357_9BDF, ~32'h1357_9BDF, 0, -1, 32, 0, 0};
    tbl[3] = '{32'hDEAD_BEEF, 32'hDEAD_BEEF ^ 32'h8000_0000, 0, -1, 1, 31, 0};
    tbl[4] = '{32'h0000_FFFF, 32'h0000_FFFF ^ 32'h8000_0001, 0, -1, 2, 0, 0};
    tbl[5] = '{32'hCAFE_F00D, 32'hCAFE_F00D, 1, 10, 0, 0, 1};

    #12;
    chk("reset.outputs", {busy1, done1, pass1, seen1, vec1, cnt1, first1}, 0);
    chk("reset.outputs3", {busy3, done3, pass3, seen3, vec3, cnt3, first3}, 0);
    @(negedge clk); reset = 0;

    for (int i = 0; i < 6; i++)
      sweep($sformatf("tbl%0d", i), tbl[i].s3, tbl[i].a, tbl[i].b, tbl[i].restart_at,
            tbl[i].exp_cnt, tbl[i].exp_first, tbl[i].exp_pass);

    // abort during WAIT, then during SAMPLE (that sample still counts)
    abort_test("abort_wait", 32'h2468_ACE0, ~32'h2468_ACE0, 21);
    abort_test("abort_sample", 32'h2468_ACE0, ~32'h2468_ACE0, 22);
    held = cnt_o;

    // start and abort together in IDLE: nothing starts, results hold
    @(negedge clk); start = 1; abort = 1;
    @(posedge clk); #1; start = 0; abort = 0;
    chk("idle_abort_start.busy", busy_o, 0);
    chk("idle_abort_start.hold", cnt_o, held);
    sweep("after_abort", 0, 32'h5555_AAAA, 32'h5555_AAAA, -1, 0, 0, 1);

    // asynchronous reset between edges mid-sweep
    ta = 32'h1111_2222; tb = ~ta; sel = 0;
    @(negedge clk); start = 1;
    @(posedge clk); #1; start = 0;
    repeat (29) @(posedge clk);
    #3; reset = 1; #1;
    chk("reset_mid.outputs", {busy1, done1, pass1, seen1, vec1, cnt1, first1}, 0);
    @(negedge clk); reset = 0;
    @(posedge clk); #1;
    chk("reset_mid.idle", {busy1, done1, vec1}, 0);

    // randomized truth tables against the popcount model
    for (int i = 0; i < 8; i++) begin
      bit s3;
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rm = 0;
        1: rm = 32'h1 << $urandom_range(0, 31);
        2: rm = $urandom & $urandom & $urandom;
        default: rm = $urandom;
      endcase
      s3 = 1'($urandom_range(0, 1));
      sweep($sformatf("rnd%0d", i), s3, ra, ra ^ rm, -1,
            diff_count(rm, 32), lowest(rm), rm == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
